// File: rtl/add_norm_pipe.sv
// Add/sub significand adder with leading-zero normalisation, two register stages
// and a valid/ready handshake feeding the rounding stage.
module add_norm_pipe #(
    parameter int FractionSize = 23,
    parameter int ExponentSize = 8,
    localparam int MantissaSize = FractionSize + 1,
    localparam int RoundingSize = MantissaSize + 3,
    localparam int ShiftSize = $clog2(RoundingSize + 1)
) (
    input  logic                    Clk,
    input  logic                    RstN,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [RoundingSize-1:0] Adder1,
    input  logic [RoundingSize-1:0] Adder2,
    input  logic                    EffOperation,
    input  logic [ExponentSize-1:0] ExpIn,
    input  logic                    SignIn,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [RoundingSize-1:0] NormMantissa,
    output logic [ExponentSize-1:0] NormExponent,
    output logic [ShiftSize-1:0]    NormShifts,
    output logic                    EffCarry,
    output logic                    SignOut,
    output logic                    ZeroResult,
    output logic                    Tiny,
    output logic                    ExpOverflow
);

    localparam int CmpW = (ExponentSize > ShiftSize) ? ExponentSize : ShiftSize;

    // Leading-zero count; scanning upwards leaves the position of the highest set bit.
    function automatic logic [ShiftSize-1:0] lzc(input logic [RoundingSize-1:0] v);
        logic [ShiftSize-1:0] n;
        n = ShiftSize'(RoundingSize);
        for (int i = 0; i < RoundingSize; i++) begin
            n = v[i] ? ShiftSize'(RoundingSize - 1 - i) : n;
        end
        return n;
    endfunction

    logic                    rdy_q;
    logic                    v1_q, v2_q;
    logic                    carry1_q, effop1_q, sign1_q;
    logic [RoundingSize-1:0] sum1_q;
    logic [ExponentSize-1:0] exp1_q;

    logic                    en1_s, en2_s, in_ready_s;
    logic [ShiftSize-1:0]    lz_s;
    logic                    eff_carry_s;
    logic [ExponentSize-1:0] sub_shift_s;
    logic [RoundingSize-1:0] mant_d;
    logic [ExponentSize-1:0] exp_d;
    logic [ShiftSize-1:0]    shifts_d;
    logic                    zero_d, tiny_d, ovf_d;

    assign en2_s      = ~v2_q | OutReady;
    assign en1_s      = ~v1_q | en2_s;
    assign in_ready_s = en1_s & rdy_q;
    assign InReady    = in_ready_s;
    assign OutValid   = v2_q;

    // Normalisation of the registered raw sum, in priority order zero/carry/normal/subnormal.
    always_comb begin
        lz_s        = lzc(sum1_q);
        eff_carry_s = carry1_q & ~effop1_q;
        mant_d      = '0;
        exp_d       = '0;
        shifts_d    = lz_s;
        zero_d      = 1'b0;
        tiny_d      = 1'b0;
        ovf_d       = 1'b0;
        sub_shift_s = '0;
        if (~eff_carry_s && (sum1_q == '0)) begin
            zero_d = 1'b1;
        end else if (eff_carry_s) begin
            // The carry counts as the leading one, so the raw sum needs no left shift.
            mant_d   = {1'b1, sum1_q[RoundingSize-1:2], sum1_q[1] | sum1_q[0]};
            exp_d    = exp1_q + ExponentSize'(1);
            ovf_d    = ((exp1_q + ExponentSize'(1)) == {ExponentSize{1'b1}});
            shifts_d = '0;
        end else if (CmpW'(lz_s) < CmpW'(exp1_q)) begin
            mant_d = sum1_q << lz_s;
            exp_d  = exp1_q - ExponentSize'(lz_s);
        end else begin
            sub_shift_s = (exp1_q == '0) ? '0 : (exp1_q - ExponentSize'(1));
            mant_d      = sum1_q << sub_shift_s;
            tiny_d      = 1'b1;
        end
    end

    // Input acceptance is held off until the first clock after reset release.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Stage 1: significand add with carry out, plus the side-band fields.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            v1_q     <= 1'b0;
            carry1_q <= 1'b0;
            sum1_q   <= '0;
            effop1_q <= 1'b0;
            exp1_q   <= '0;
            sign1_q  <= 1'b0;
        end else if (en1_s) begin
            v1_q <= InValid & in_ready_s;
            if (InValid & in_ready_s) begin
                {carry1_q, sum1_q} <= {1'b0, Adder1} + {1'b0, Adder2};
                effop1_q           <= EffOperation;
                exp1_q             <= ExpIn;
                sign1_q            <= SignIn;
            end
        end
    end

    // Stage 2: registered normalised result, held while downstream stalls.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            v2_q         <= 1'b0;
            NormMantissa <= '0;
            NormExponent <= '0;
            NormShifts   <= '0;
            EffCarry     <= 1'b0;
            SignOut      <= 1'b0;
            ZeroResult   <= 1'b0;
            Tiny         <= 1'b0;
            ExpOverflow  <= 1'b0;
        end else if (en2_s) begin
            v2_q <= v1_q;
            if (v1_q) begin
                NormMantissa <= mant_d;
                NormExponent <= exp_d;
                NormShifts   <= shifts_d;
                EffCarry     <= eff_carry_s;
                SignOut      <= sign1_q;
                ZeroResult   <= zero_d;
                Tiny         <= tiny_d;
                ExpOverflow  <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_add_norm_pipe.sv
// Scoreboard bench for add_norm_pipe (single precision): directed corner cases,
// back-pressure, mid-flight reset and randomised traffic against an arithmetic model.
module tb_add_norm_pipe;

    localparam longint TWO27 = 64'd134217728;
    localparam longint TWO26 = 64'd67108864;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [26:0] Adder1 = 27'd0;
    logic [26:0] Adder2 = 27'd0;
    logic        EffOperation = 1'b0;
    logic [7:0]  ExpIn = 8'd0;
    logic        SignIn = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [26:0] NormMantissa;
    logic [7:0]  NormExponent;
    logic [4:0]  NormShifts;
    logic        EffCarry, SignOut, ZeroResult, Tiny, ExpOverflow;

    add_norm_pipe dut (
        .Clk(Clk), .RstN(RstN), .InValid(InValid), .InReady(InReady),
        .Adder1(Adder1), .Adder2(Adder2), .EffOperation(EffOperation),
        .ExpIn(ExpIn), .SignIn(SignIn), .OutValid(OutValid), .OutReady(OutReady),
        .NormMantissa(NormMantissa), .NormExponent(NormExponent), .NormShifts(NormShifts),
        .EffCarry(EffCarry), .SignOut(SignOut), .ZeroResult(ZeroResult), .Tiny(Tiny),
        .ExpOverflow(ExpOverflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        longint mant;
        longint expo;
        longint shifts;
        bit     ec;
        bit     sign;
        bit     zero;
        bit     tiny;
        bit     ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;
    bit   rand_bp = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Result computed from the arithmetic rules: integer add, normalise by doubling.
    function automatic exp_t model(longint a1, longint a2, bit op, longint e, bit s);
        exp_t   r;
        longint total, sum, t, sh;
        int     lz;
        bit     carry;
        total = a1 + a2;
        carry = (total >= TWO27);
        sum   = total % TWO27;
        r = '{mant: 0, expo: 0, shifts: 0, ec: 1'b0, sign: s, zero: 1'b0, tiny: 1'b0, ovf: 1'b0};
        r.ec = carry && !op;
        lz = 0;
        if (sum == 0) lz = 27;
        else begin
            t = sum;
            while (t < TWO26) begin t = t * 2; lz++; end
        end
        r.shifts = r.ec ? 0 : lz;
        if (!r.ec && sum == 0) r.zero = 1'b1;
        else if (r.ec) begin
            r.mant = TWO26 + (sum / 4) * 2 + (((sum % 4) != 0) ? 1 : 0);
            r.expo = (e + 1) % 256;
            r.ovf  = ((e + 1) == 255);
        end else if (lz < e) begin
            r.mant = sum * (64'd1 << lz);
            r.expo = e - lz;
        end else begin
            sh = (e == 0) ? 0 : e - 1;
            r.mant = (sum * (64'd1 << sh)) % TWO27;
            r.tiny = 1'b1;
        end
        return r;
    endfunction

    // Scoreboard push on every accepted operand set; reset discards in-flight expectations.
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) exp_q.delete();
        else if (InValid && InReady) begin
            exp_q.push_back(model(Adder1, Adder2, EffOperation, ExpIn, SignIn));
            accepted++;
        end
    end

    // Monitor: compare every result that is drained this cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (RstN && OutValid && OutReady) begin
            if (exp_q.size() == 0) chk("unexpected_output", 0, 1);
            else begin
                e = exp_q.pop_front();
                chk("mant", NormMantissa, e.mant);
                chk("exp", NormExponent, e.expo);
                chk("shifts", NormShifts, e.shifts);
                chk("effcarry", EffCarry, e.ec);
                chk("sign", SignOut, e.sign);
                chk("zero", ZeroResult, e.zero);
                chk("tiny", Tiny, e.tiny);
                chk("expovf", ExpOverflow, e.ovf);
            end
        end
    end

    task automatic send(input logic [26:0] a1, input logic [26:0] a2, input bit op,
                        input logic [7:0] e, input bit s);
        bit r = 1'b0;
        Adder1 = a1; Adder2 = a2; EffOperation = op; ExpIn = e; SignIn = s;
        InValid = 1'b1;
        for (int i = 0; i < 50 && !r; i++) begin
            if (rand_bp) OutReady = ($urandom_range(0, 3) != 0);
            @(negedge Clk);
            r = InReady;
            @(posedge Clk);
            #1;
        end
        if (!r) chk("send_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input logic [26:0] a1, input logic [26:0] a2,
                            input bit op, input logic [7:0] e, input longint m,
                            input longint x, input longint sh, input bit ec,
                            input bit z, input bit t, input bit ov);
        bit seen = 1'b0;
        send(a1, a2, op, e, 1'b0);
        InValid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            seen = OutValid;
        end
        chk({name, "_valid"}, seen, 1);
        chk({name, "_mant"}, NormMantissa, m);
        chk({name, "_exp"}, NormExponent, x);
        chk({name, "_shifts"}, NormShifts, sh);
        chk({name, "_effcarry"}, EffCarry, ec);
        chk({name, "_zero"}, ZeroResult, z);
        chk({name, "_tiny"}, Tiny, t);
        chk({name, "_ovf"}, ExpOverflow, ov);
        @(posedge Clk); #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge Clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [26:0] snap_m;
        logic [7:0]  snap_e;
        logic [26:0] a1, b;
        bit          op;
        int          acc0;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_inready", InReady, 0);
        chk("rst_mant", NormMantissa, 0);
        chk("rst_exp", NormExponent, 0);
        RstN = 1'b1;
        #1 chk("rel_inready_low", InReady, 0);
        @(negedge Clk);
        chk("rel_inready_high", InReady, 1);
        @(posedge Clk); #1;

        directed("add_ovf", 27'h4000000, 27'h4000000, 1'b0, 8'd127, 64'h4000000, 128, 0, 1, 0, 0, 0);
        directed("cancel", 27'h4000008, 27'h4000000, 1'b1, 8'd127, 64'h4000000, 104, 23, 0, 0, 0, 0);
        directed("zero", 27'h4000000, 27'h4000000, 1'b1, 8'd90, 0, 0, 27, 0, 1, 0, 0);
        directed("subnorm", 27'h4000008, 27'h4000000, 1'b1, 8'd5, 64'h80, 0, 23, 0, 0, 1, 0);
        directed("exp_ovf", 27'h4000000, 27'h4000000, 1'b0, 8'd254, 64'h4000000, 255, 0, 1, 0, 0, 1);
        directed("sticky", 27'h4000003, 27'h4000000, 1'b0, 8'd10, 64'h4000001, 11, 0, 1, 0, 0, 0);

        // Back-pressure: two accepted, third refused, outputs frozen
        OutReady = 1'b0;
        acc0 = accepted;
        send(27'h4000001, 27'h0000100, 1'b0, 8'd60, 1'b1);
        send(27'h5000000, 27'h0000003, 1'b0, 8'd61, 1'b0);
        Adder1 = 27'h4400000; Adder2 = 27'h0000020; ExpIn = 8'd62; InValid = 1'b1;
        @(negedge Clk);
        chk("bp_inready", InReady, 0);
        chk("bp_outvalid", OutValid, 1);
        snap_m = NormMantissa; snap_e = NormExponent;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("bp_hold_mant", NormMantissa, snap_m);
            chk("bp_hold_exp", NormExponent, snap_e);
            chk("bp_hold_valid", OutValid, 1);
        end
        chk("bp_accepted", accepted - acc0, 2);
        @(posedge Clk); #1;
        OutReady = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        wait_drain();
        chk("bp_total_accepted", accepted - acc0, 3);

        // Reset with both stages full
        OutReady = 1'b0;
        send(27'h4000000, 27'h0000011, 1'b0, 8'd40, 1'b0);
        send(27'h4000000, 27'h0000022, 1'b0, 8'd41, 1'b0);
        InValid = 1'b0;
        @(posedge Clk); #3;
        chk("rst_full_outvalid_before", OutValid, 1);
        RstN = 1'b0;
        #1 chk("rst_full_outvalid", OutValid, 0);
        OutReady = 1'b1;
        repeat (2) @(posedge Clk);
        #2 RstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("no_stale", OutValid, 0);
        end
        @(posedge Clk); #1;

        // Randomised traffic with random back-pressure
        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 1);
            a1 = 27'($urandom_range(0, 32'h7FFFFFF));
            if ($urandom_range(0, 1) == 1) a1[26] = 1'b1;
            if (!op) b = 27'($urandom_range(0, 32'h7FFFFFF));
            else if ($urandom_range(0, 2) == 0) b = a1 - 27'($urandom_range(0, 300) % (a1 + 1));
            else b = 27'($urandom_range(0, a1));
            send(a1, op ? (27'd0 - b) : b, op,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                InValid = 1'b0;
                @(posedge Clk); #1;
            end
        end
        InValid = 1'b0;
        rand_bp = 1'b0;
        OutReady = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
